// File: rtl/stream_pkg.sv
// ---------------------------------------------------------------------------
// stream_pkg
// Shared definitions for the stream burst writer: FSM state encoding, default
// sizing constants and a clog2 helper for port/counter widths.
// ---------------------------------------------------------------------------
package stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_CMD     = 3'd2,
        ST_DATA    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // clog2 that never returns 0, so a width derived from it is always legal
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

    localparam int unsigned DEF_BURST_LEN  = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 32;
    localparam int unsigned DEF_LEN_W      = clog2_min1(DEF_BURST_LEN);

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head word is visible on
// o_rdata whenever o_empty is low; i_pop consumes it.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (pointers only)
//   i_push/i_wdata write request and data (ignored when full)
//   i_pop          read request (ignored when empty)
//   o_rdata        head word
//   o_count        words held, 0..DEPTH
//   o_full/o_empty status flags
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_wdata,
    input  logic                       i_pop,
    output logic [DW-1:0]              o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW:0]   r_wptr;
    logic [PW:0]   r_rptr;
    logic          w_push;
    logic          w_pop;

    assign o_count = r_wptr - r_rptr;
    assign o_full  = (o_count == CW'(DEPTH));
    assign o_empty = (o_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_rdata = r_mem[r_rptr[PW-1:0]];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage is not reset; reset empties the FIFO through the pointers
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[PW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/stream_burst_writer.sv
// ---------------------------------------------------------------------------
// stream_burst_writer
// Buffers a framed stream of wide words and writes it to memory as bursts of
// incrementing word addresses. start_i arms one frame at base_addr_i; the
// frame ends with the beat tagged s_last_i. Full bursts are BURST_LEN beats,
// the frame tail goes out as one shorter burst, then done_o pulses.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   start_i, base_addr_i               frame arm pulse and first word address
//   s_data_i/s_valid_i/s_last_i/s_ready_o   input stream
//   cmd_valid_o/cmd_ready_i/cmd_addr_o/cmd_len_o   burst command (len = beats-1)
//   wr_data_o/wr_valid_o/wr_ready_i/wr_last_o       burst write data
//   busy_o                             frame armed or in progress
//   done_o                             one-cycle pulse after the last burst
// ---------------------------------------------------------------------------
module stream_burst_writer
    import stream_pkg::*;
#(
    parameter int DW         = 64,
    parameter int AW         = 24,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic [AW-1:0]                     base_addr_i,
    input  logic [DW-1:0]                     s_data_i,
    input  logic                              s_valid_i,
    input  logic                              s_last_i,
    output logic                              s_ready_o,
    output logic                              cmd_valid_o,
    input  logic                              cmd_ready_i,
    output logic [AW-1:0]                     cmd_addr_o,
    output logic [clog2_min1(BURST_LEN)-1:0]  cmd_len_o,
    output logic [DW-1:0]                     wr_data_o,
    output logic                              wr_valid_o,
    input  logic                              wr_ready_i,
    output logic                              wr_last_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int LW = clog2_min1(BURST_LEN);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] BL_CNT = CW'(BURST_LEN);

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_addr;
    logic [LW-1:0]   r_cmd_len;
    logic [LW-1:0]   r_beat;
    logic            r_last_seen;

    logic            w_len_load;
    logic [LW-1:0]   w_len_nxt;
    logic            w_busy;
    logic            w_push;
    logic            w_wr_hs;
    logic            w_final;
    logic            w_start;
    logic [DW-1:0]   w_rdata;
    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (s_data_i),
        .i_pop   (w_wr_hs),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_busy  = (r_state == ST_COLLECT) || (r_state == ST_CMD) || (r_state == ST_DATA);
    assign w_start = (r_state == ST_IDLE) && start_i;

    // Input stops once the frame's last beat is in, so a second frame can
    // never mix into the tail of this one
    assign s_ready_o = w_busy & ~w_full & ~r_last_seen;
    assign w_push    = s_valid_i & s_ready_o;

    assign cmd_valid_o = (r_state == ST_CMD);
    assign cmd_addr_o  = r_addr;
    assign cmd_len_o   = r_cmd_len;

    // The burst was only launched with enough words buffered, so the empty
    // term is a guard rather than a real stall source
    assign wr_valid_o = (r_state == ST_DATA) & ~w_empty;
    assign wr_last_o  = wr_valid_o & (r_beat == r_cmd_len);
    assign wr_data_o  = wr_valid_o ? w_rdata : '0;
    assign w_wr_hs    = wr_valid_o & wr_ready_i;
    assign w_final    = w_wr_hs & (r_beat == r_cmd_len);

    assign busy_o = w_busy;
    assign done_o = (r_state == ST_DONE);

    always_comb begin
        w_next     = r_state;
        w_len_load = 1'b0;
        w_len_nxt  = '0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) w_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                // Full bursts take priority; the partial tail only goes once
                // fewer than BURST_LEN words remain after the last beat
                if (w_count >= BL_CNT) begin
                    w_next     = ST_CMD;
                    w_len_load = 1'b1;
                    w_len_nxt  = LW'(BURST_LEN - 1);
                end else if (r_last_seen && !w_empty) begin
                    w_next     = ST_CMD;
                    w_len_load = 1'b1;
                    w_len_nxt  = LW'(w_count - CW'(1));
                end else if (r_last_seen) begin
                    w_next = ST_DONE;
                end
            end
            ST_CMD: begin
                if (cmd_ready_i) w_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_final) w_next = ST_COLLECT;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_cmd_len   <= '0;
            r_beat      <= '0;
            r_last_seen <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_start)
                r_addr <= base_addr_i;
            else if (w_final)
                r_addr <= r_addr + AW'(r_cmd_len) + AW'(1);  // wraps modulo 2^AW

            if (w_len_load) r_cmd_len <= w_len_nxt;

            if (w_final)
                r_beat <= '0;
            else if (w_wr_hs)
                r_beat <= r_beat + LW'(1);

            if (w_start || (r_state == ST_DONE))
                r_last_seen <= 1'b0;
            else if (w_push && s_last_i)
                r_last_seen <= 1'b1;
        end
    end

endmodule
